// File: rtl/iter_shift_unit.sv
// Iterative shift/rotate unit: SHL/SHR/SHRA/ROL/ROR performed at most
// STEP bit positions per clock, with a start/busy/done handshake toward
// the datapath sequencer. busy/done/result are registered one edge after
// the internal state, so done appears in the cycle after edge E0+n+1.
module iter_shift_unit #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5,
  parameter int STEP  = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amt_in,
  output logic             busy,
  output logic             done,
  output logic             bad_op,
  output logic             zero,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  // Step sizes held one bit wider than the amount so STEP == WIDTH fits.
  localparam logic [AMT_W:0] STEP_K  = (AMT_W+1)'(STEP);
  localparam logic [AMT_W:0] WIDTH_K = (AMT_W+1)'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W:0]   k;
  logic             busy_q, done_q, bad_op_q, zero_q;
  logic [WIDTH-1:0] result_q;

  // One shift/rotate step of k positions (1 <= k < WIDTH during SHIFT).
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] w,
    input logic [2:0]       o,
    input logic [AMT_W:0]   kk
  );
    logic signed [WIDTH-1:0] ws;
    logic [AMT_W:0]          kr;
    ws = signed'(w);
    kr = WIDTH_K - kk;
    case (o)
      3'd0:    shift_step = w << kk;
      3'd1:    shift_step = w >> kk;
      3'd2:    shift_step = unsigned'(ws >>> kk);
      3'd3:    shift_step = (w << kk) | (w >> kr);
      3'd4:    shift_step = (w >> kk) | (w << kr);
      default: shift_step = w;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [2:0] o);
    is_illegal = (o > 3'd4);
  endfunction

  // Step size: the smaller of STEP and the remaining amount.
  always_comb begin
    k = {1'b0, rem_q};
    if ({1'b0, rem_q} > STEP_K) k = STEP_K;
  end

  // Next-state and working-register update.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = data_in;
          rem_d   = amt_in;
          op_d    = op;
          state_d = (amt_in == '0 || is_illegal(op)) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        work_d = shift_step(work_q, op_q, k);
        rem_d  = rem_q - k[AMT_W-1:0];
        if ({1'b0, rem_q} == k) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, working registers and registered handshake/result outputs.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bad_op_q <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      busy_q   <= (state_q != S_IDLE);
      done_q   <= (state_q == S_DONE);
      bad_op_q <= (state_q == S_DONE) && is_illegal(op_q);
      if (state_q == S_DONE) begin
        result_q <= work_q;
        zero_q   <= (work_q == '0);
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign bad_op = bad_op_q;
  assign zero   = zero_q;
  assign result = result_q;

endmodule
